buffer_arbiter: RTL
===================

# buffer_arbiter

Two-writer, one-reader controller for a shared circular buffer. It arbitrates round-robin between two producers competing for a single write slot per cycle, and sequences the read and write pointers. It also reports occupancy. It sits between the producer stages and the consumer, and wraps an internal storage array.

## Interface
- DW, 32, data word width
- AW, 3, address width; depth = 2**AW entries (8 by default)

- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req0  in  1  requester 0 wants to write data0 this cycle
- data0  in  DW  requester 0 write data
- gnt0  out  1  requester 0 write accepted this cycle (combinational)
- req1  in  1  requester 1 wants to write data1 this cycle
- data1  in  DW  requester 1 write data
- gnt1  out  1  requester 1 write accepted this cycle (combinational)
- rd_en  in  1  consumer requests one word
- rd_data  out  DW  registered read data
- rd_valid  out  1  rd_data holds a word popped on the previous edge
- empty  out  1  count == 0
- full  out  1  count == 2**AW
- count  out  AW+1  number of stored words

## Operation
- State: wr_ptr, rd_ptr (AW bits each, wrap naturally from 2**AW-1 to 0), count (AW+1 bits), prio (1 bit, requester holding priority), rd_data, rd_valid.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, prio=0, rd_data=0, rd_valid=0. Hence empty=1, full=0, gnt0=gnt1=0.
- Arbitration:
  - Grants only when !full.
  - Only one requester asserted -> that requester is granted.
  - Both asserted -> the requester equal to prio is granted.
  - gnt0 and gnt1 are never both 1.
- Priority update: on an edge with a grant to i, prio <= ~i. With no grant, prio holds. Two continuous requesters therefore alternate 0,1,0,1…
- Write: on a granted edge, mem[wr_ptr] <= granted data; wr_ptr <= wr_ptr+1.
- Read accept: rd_en && !empty. On that edge, rd_data <= mem[rd_ptr], rd_ptr <= rd_ptr+1, and rd_valid <= 1. rd_valid <= 0 on every edge with no accepted read. rd_data holds its value when no read is accepted.
- rd_en while empty is ignored: no pointer move, rd_valid <= 0.
- Count: +1 on write only, -1 on read only, unchanged on both or neither.
- Simultaneous read and write when empty: the write is accepted and the read is ignored. Data is not bypassed.
- Simultaneous read and write when full: the write is refused (gnt=0) and the read proceeds. Count becomes 2**AW-1.
- Data of a non-granted requester is dropped. The requester must hold req and data until it sees gnt.

## Timing
- gnt0/gnt1 are combinational from req0, req1, full, prio in the same cycle. There is no combinational path from data to gnt.
- Write latency: data is stored at the granting edge. It is readable at the earliest by an rd_en in the next cycle.
- Read latency: 1 cycle. rd_en accepted at edge N gives rd_data/rd_valid valid after edge N, for one cycle.
- empty, full, count are registered-state derived and update after the edge.
- Asserting reset mid-operation clears pointers, count, prio, rd_valid, and rd_data asynchronously. Buffer contents become don't-care. The first edge after deassertion behaves as post-reset.

## Structure
- Shared header buffer_defs.vh holds the default DW and AW and the requester index constants REQ0=1'b0 and REQ1=1'b1.
- The sub-module buffer_mem is the storage: 2**AW x DW array with a synchronous write port and an asynchronous read port. It is not reset.
- buffer_arbiter contains the arbiter, pointer and count logic, and the read register.

## Test plan
- Reset then idle -> empty=1, full=0, count=0, rd_valid=0, gnt0=gnt1=0.
- Both requesters held high with data0=0xA0+k and data1=0xB0+k for 4 cycles -> grants alternate 0,1,0,1. Draining gives rd_data 0xA0,0xB1,0xA2,0xB3, with rd_valid one cycle after each rd_en.
- Only req1 for 8 cycles -> full=1, count=8, and gnt1 drops on the 9th cycle. A rd_en with req1 on a full buffer gives gnt1=0 and count=7.
- Fill 6 words, read 6, then write and read 6 more -> pointers wrap past 7. Data order is preserved and count returns to 0.
- rd_en on an empty buffer with req0 in the same cycle -> gnt0=1, rd_valid=0 next cycle, count=1.
- Assert reset asynchronously mid-stream with count=5 -> count=0, empty=1, rd_valid=0 before the next clock edge, and prio=0 afterwards (both requesting gives gnt0).

Source files
------------

// File: rtl/buffer_arbiter_pkg.sv
// Shared definitions for the two-writer circular buffer controller:
// default widths, requester indices and the round-robin grant helper.
package buffer_arbiter_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 3;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_0    = 2'b01,
    GRANT_1    = 2'b10
  } grant_e;

  // A lone requester always wins; a tie goes to whoever holds priority.
  // A blocked (full) buffer grants nobody.
  function automatic grant_e pick_grant(input logic req0,
                                        input logic req1,
                                        input logic prio,
                                        input logic blocked);
    grant_e g;
    g = GRANT_NONE;
    if (!blocked) begin
      if (req0 && req1) begin
        g = (prio == REQ0) ? GRANT_0 : GRANT_1;
      end else if (req0) begin
        g = GRANT_0;
      end else if (req1) begin
        g = GRANT_1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/buffer_arbiter_mem.sv
// Storage array for the circular buffer: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module buffer_mem #(
  parameter int DW = 32,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Store the granted word at the write pointer on the rising edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/buffer_arbiter.sv
// Two-producer, one-consumer controller around a shared circular buffer.
// Arbitrates the single write slot round-robin, sequences the read and
// write pointers, tracks occupancy and registers the read data.
module buffer_arbiter
  import buffer_arbiter_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          gnt1,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          prio;
  grant_e        grant;
  logic          wr_accept;
  logic          rd_accept;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mem_rd_data;

  assign empty = (count == '0);
  assign full  = (count == DEPTH);

  // Grants depend only on requests, fullness and priority, never on data.
  always_comb begin
    grant   = pick_grant(req0, req1, prio, full);
    gnt0    = (grant == GRANT_0);
    gnt1    = (grant == GRANT_1);
    wr_data = (grant == GRANT_1) ? data1 : data0;
  end

  assign wr_accept = gnt0 | gnt1;
  assign rd_accept = rd_en & ~empty;

  buffer_mem #(
    .DW(DW),
    .AW(AW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_accept),
    .wr_addr(wr_ptr),
    .wr_data(wr_data),
    .rd_addr(rd_ptr),
    .rd_data(mem_rd_data)
  );

  // Pointers wrap naturally; count moves only when exactly one side acts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_accept && !rd_accept) begin
        count <= count + 1'b1;
      end else if (rd_accept && !wr_accept) begin
        count <= count - 1'b1;
      end
    end
  end

  // Priority passes to the other requester after every grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= REQ0;
    end else if (gnt0) begin
      prio <= REQ1;
    end else if (gnt1) begin
      prio <= REQ0;
    end
  end

  // Read register: captures the head word on an accepted read, else holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        rd_data <= mem_rd_data;
      end
    end
  end

endmodule
